v2_pulse_gen: RTL and testbench
===============================

# v2_pulse_gen

- Synthetic detector-pulse source that drives the V2 shaping filter input.
- Turns amplitude requests into discrete exponential pulses with a linear leading edge and pile-up summation.
- Decay is `y <= y - (y >> V2_TAU_SHIFT)`. The filter's exact deconvolution constant is therefore `V2_M = 2**V2_TAU_SHIFT - 1`, so a correctly parameterised filter returns flat-top trapezoids.
- Used in bench and on-board self-test in place of the ADC stream.

## Interface
Parameters:
- WIDTH, default V2_WIDTH (16): sample width, unsigned.
- TAU_SHIFT, default V2_TAU_SHIFT (5): decay shift; time constant ≈ 2^TAU_SHIFT clocks.
- RISE_LOG2, default 2: leading edge lasts R = 2^RISE_LOG2 cycles.

Ports:
- clk, input, 1: clock (clk).
- reset, input, 1: reset. Synchronous, active-high.
- trig_valid, input, 1: pulse request.
- trig_amp, input, WIDTH: pulse amplitude, unsigned.
- trig_ready, output, 1: request can be accepted this cycle.
- out, output, WIDTH: sample stream to the filter; registered.
- busy, output, 1: state is not IDLE.
- pulse_cnt, output, 16: accepted requests, wraps at 65535→0.

## Operation
- State machine with three states:
  - IDLE: out == 0. On accept, go to RISE.
  - RISE: R cycles of linear rise, no decay. After R steps, go to DECAY.
  - DECAY: each cycle `out <= out - max(out >> TAU_SHIFT, 1)` when out > 0. Go to IDLE on the edge where out becomes 0. An accept in DECAY goes to RISE (pile-up).
- Handshake: accept = trig_valid & trig_ready. trig_ready = (state != RISE). A request during RISE waits; trig_valid/trig_amp must stay stable until accepted.
- On accept:
  - latch step = trig_amp >> RISE_LOG2 and rem = trig_amp - step·(R-1).
  - rise counter = 0.
  - pulse_cnt += 1.
  - In DECAY, the decay step of that same cycle is still applied.
- RISE arithmetic:
  - steps 1..R-1 add step; step R adds rem, so the total added is exactly trig_amp.
  - Every addition saturates at 2^WIDTH-1, with no wrap.
- Decay arithmetic:
  - The forced minimum decrement of 1 guarantees termination.
  - The tail below 2^TAU_SHIFT deviates from an ideal exponential; this is accepted.
- Zero amplitude: accepted and counted. Passes through RISE adding 0, then DECAY. If out == 0, IDLE on the next cycle.
- reset has priority over everything:
  - out = 0, state = IDLE, pulse_cnt = 0, step/rem/counter = 0, trig_ready = 1, busy = 0.
  - An in-flight pulse is discarded, including mid-RISE.

## Timing
- Accept at edge N: state = RISE after edge N; busy = 1 and trig_ready = 0 from then.
- out increments on edges N+1..N+R; out = start + trig_amp (saturated) after edge N+R, where start = out after edge N.
- State is DECAY after edge N+R. trig_ready = 1 from then, so the earliest next accept is edge N+R+1.
- First decay on edge N+R+1.
- pulse_cnt updates on the accept edge.
- Outputs after reset: out = 0, trig_ready = 1, busy = 0, pulse_cnt = 0.
- Latency from request to peak is R+1 clocks from trig_valid high (with ready high).

## Structure
- V2_param additions:
  - V2_TAU_SHIFT.
  - V2_RISE_LOG2.
  - V2_M redefined as 2**V2_TAU_SHIFT - 1.
  - typedef enum logic [1:0] {PG_IDLE, PG_RISE, PG_DECAY} v2_pg_state_t.
- One sub-module, v2_sat_add: WIDTH-bit unsigned saturating adder, shared by the RISE path and future blocks.
- Everything else is one always_ff plus combinational next-value logic.

## Test plan
- Single pulse (TAU_SHIFT=5, R=4, amp=1024 at edge N):
  - out = 256, 512, 768, 1024 on N+1..N+4, then 992, 961, 931.
  - Eventually 0 with busy falling.
  - pulse_cnt = 1.
- Remainder (amp=1023): out = 255, 510, 765, 1023; peak exact.
- Pile-up: second amp=512 accepted 10 cycles after peak at out = V. Rise adds 128×3 + 128, with the decay applied on the accept edge. Request held during RISE waits, with trig_ready = 0 for exactly 4 cycles.
- Saturation (WIDTH=16): amp=60000 then amp=60000 during DECAY. out clamps at 65535, no wrap.
- Reset mid-RISE: out = 0, state IDLE, pulse_cnt = 0 on the next edge; the held request is accepted the cycle after reset drops.
- Loopback: feed out into V2_filter with V2_M = 31. Each isolated pulse yields a trapezoid whose flat top is constant within ±1 LSB.

Source files
------------

// File: rtl/v2_pulse_gen_pkg.sv
// Shared V2 constants and types for the synthetic pulse source and its shaping filter.
package v2_pulse_gen_pkg;

    localparam int V2_WIDTH     = 16;
    localparam int V2_TAU_SHIFT = 5;
    localparam int V2_RISE_LOG2 = 2;

    // Exact deconvolution constant matching a decay of y - (y >> V2_TAU_SHIFT).
    localparam int V2_M = 2**V2_TAU_SHIFT - 1;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_RISE,
        PG_DECAY
    } v2_pg_state_t;

endpackage

// File: rtl/v2_pulse_gen_sat_add.sv
// Unsigned saturating adder: the result clamps at 2^WIDTH-1 instead of wrapping.
module v2_sat_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};
    assign y   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

endmodule

// File: rtl/v2_pulse_gen.sv
// Synthetic detector pulses: linear leading edge over 2^RISE_LOG2 cycles, then an
// exponential tail y - (y >> TAU_SHIFT), with pile-up summation of overlapping requests.
module v2_pulse_gen
    import v2_pulse_gen_pkg::*;
#(
    parameter int WIDTH     = V2_WIDTH,
    parameter int TAU_SHIFT = V2_TAU_SHIFT,
    parameter int RISE_LOG2 = V2_RISE_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig_valid,
    input  logic [WIDTH-1:0] trig_amp,
    output logic             trig_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic [15:0]      pulse_cnt
);

    localparam int R  = 1 << RISE_LOG2;
    localparam int CW = (RISE_LOG2 > 0) ? RISE_LOG2 : 1;
    localparam logic [CW-1:0] RISE_LAST = CW'(R - 1);

    v2_pg_state_t     state_r, state_d;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] step_r, step_d;
    logic [WIDTH-1:0] rem_r, rem_d;
    logic [CW-1:0]    cnt_r, cnt_d;
    logic [15:0]      pcnt_d;

    logic             accept;
    logic             rise_last;
    logic [WIDTH-1:0] rise_add;
    logic [WIDTH-1:0] rise_sum;
    logic [WIDTH-1:0] tail_shift;
    logic [WIDTH-1:0] tail_dec;
    logic [WIDTH-1:0] new_step;
    logic [WIDTH-1:0] new_rem;

    assign trig_ready = (state_r != PG_RISE);
    assign busy       = (state_r != PG_IDLE);
    assign accept     = trig_valid & trig_ready;

    // rem = amp - step*(R-1) = step + (amp mod R), so the R additions sum to exactly amp.
    assign new_step = trig_amp >> RISE_LOG2;
    assign new_rem  = new_step + (trig_amp & WIDTH'(R - 1));

    assign rise_last = (cnt_r == RISE_LAST);
    assign rise_add  = rise_last ? rem_r : step_r;

    // Forced minimum decrement of 1 guarantees the tail reaches zero.
    assign tail_shift = out >> TAU_SHIFT;
    assign tail_dec   = (tail_shift == '0) ? WIDTH'(1) : tail_shift;

    v2_sat_add #(.WIDTH(WIDTH)) u_rise_add (
        .a (out),
        .b (rise_add),
        .y (rise_sum)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_r;
        out_d   = out;
        step_d  = step_r;
        rem_d   = rem_r;
        cnt_d   = cnt_r;
        pcnt_d  = pulse_cnt;

        unique case (state_r)
            PG_IDLE: begin
                if (accept) state_d = PG_RISE;
            end
            PG_RISE: begin
                out_d = rise_sum;
                cnt_d = cnt_r + CW'(1);
                if (rise_last) state_d = PG_DECAY;
            end
            PG_DECAY: begin
                if (out != '0) out_d = out - tail_dec;
                if (accept)              state_d = PG_RISE;
                else if (out_d == '0)    state_d = PG_IDLE;
            end
            default: begin
                state_d = PG_IDLE;
                out_d   = '0;
            end
        endcase

        if (accept) begin
            step_d = new_step;
            rem_d  = new_rem;
            cnt_d  = '0;
            pcnt_d = pulse_cnt + 16'd1;
        end
    end

    // NOTE: reset is synchronous and checked first, so it discards any in-flight pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= PG_IDLE;
            out       <= '0;
            step_r    <= '0;
            rem_r     <= '0;
            cnt_r     <= '0;
            pulse_cnt <= '0;
        end else begin
            state_r   <= state_d;
            out       <= out_d;
            step_r    <= step_d;
            rem_r     <= rem_d;
            cnt_r     <= cnt_d;
            pulse_cnt <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_v2_pulse_gen.sv
// Bench for v2_pulse_gen: queue-based behavioural model checked every cycle, plus
// directed pulses with hand-computed sample values.
module tb_v2_pulse_gen;

    localparam int W   = 16;
    localparam int R   = 4;
    localparam int TAU = 32;
    localparam int MAXV = 65535;

    logic          clk = 1'b0;
    logic          reset;
    logic          trig_valid;
    logic [W-1:0]  trig_amp;
    logic          trig_ready;
    logic [W-1:0]  out;
    logic          busy;
    logic [15:0]   pulse_cnt;

    int checks = 0;
    int errors = 0;

    v2_pulse_gen dut (
        .clk        (clk),
        .reset      (reset),
        .trig_valid (trig_valid),
        .trig_amp   (trig_amp),
        .trig_ready (trig_ready),
        .out        (out),
        .busy       (busy),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a pulse is a queue of pending additions; with nothing pending the
    // sample decays by max(y/TAU, 1) while the source is still active.
    int unsigned m_out;
    int unsigned m_adds[$];
    bit          m_busy;
    int unsigned m_cnt;
    bit          m_valid = 1'b0;
    bit          m_acc;

    always @(posedge clk) begin
        if (reset) begin
            m_out = 0;
            m_adds.delete();
            m_busy = 1'b0;
            m_cnt = 0;
            m_valid = 1'b1;
        end else begin
            m_acc = trig_valid && (m_adds.size() == 0);
            if (m_adds.size() != 0) begin
                m_out = m_out + m_adds.pop_front();
                if (m_out > MAXV) m_out = MAXV;
            end else if (m_busy) begin
                if (m_out > 0) m_out = m_out - ((m_out / TAU) > 0 ? m_out / TAU : 1);
                if (!m_acc && m_out == 0) m_busy = 1'b0;
            end
            if (m_acc) begin
                for (int i = 0; i < R; i++)
                    m_adds.push_back(i < R - 1 ? trig_amp / R : trig_amp - (trig_amp / R) * (R - 1));
                m_busy = 1'b1;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out",   out,        m_out);
            check("model_busy",  busy,       m_busy);
            check("model_ready", trig_ready, m_adds.size() == 0);
            check("model_cnt",   pulse_cnt,  m_cnt);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step_out(input string name, input int unsigned exp_out);
        tick();
        check(name, out, exp_out);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        trig_valid = 1'b0;
        trig_amp = '0;
        repeat (3) tick();
        check("rst_out", out, 0);
        check("rst_ready", trig_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt", pulse_cnt, 0);
        reset = 1'b0;
        tick();

        // Single pulse, amp 1024
        trig_valid = 1'b1; trig_amp = 16'd1024;
        tick();
        trig_valid = 1'b0;
        check("p1_cnt", pulse_cnt, 1);
        check("p1_busy", busy, 1);
        check("p1_ready", trig_ready, 0);
        step_out("p1_r1", 256);
        step_out("p1_r2", 512);
        step_out("p1_r3", 768);
        step_out("p1_peak", 1024);
        step_out("p1_d1", 992);
        step_out("p1_d2", 961);
        step_out("p1_d3", 931);
        wait_idle();
        check("p1_end_out", out, 0);
        check("p1_end_cnt", pulse_cnt, 1);

        // Remainder, amp 1023
        trig_valid = 1'b1; trig_amp = 16'd1023;
        tick();
        trig_valid = 1'b0;
        step_out("rem_r1", 255);
        step_out("rem_r2", 510);
        step_out("rem_r3", 765);
        step_out("rem_peak", 1023);
        wait_idle();

        // Pile-up: 512 accepted 10 cycles after a 1024 peak
        trig_valid = 1'b1; trig_amp = 16'd1024;
        tick();
        trig_valid = 1'b0;
        repeat (3) tick();
        step_out("pu_peak", 1024);
        repeat (9) tick();
        trig_valid = 1'b1; trig_amp = 16'd512;
        tick();
        trig_valid = 1'b0;
        check("pu_accept_out", out, 748);
        check("pu_cnt", pulse_cnt, 4);
        check("pu_ready0", trig_ready, 0);
        step_out("pu_r1", 876);
        check("pu_ready1", trig_ready, 0);
        step_out("pu_r2", 1004);
        check("pu_ready2", trig_ready, 0);
        step_out("pu_r3", 1132);
        check("pu_ready3", trig_ready, 0);
        step_out("pu_peak2", 1260);
        check("pu_ready4", trig_ready, 1);
        wait_idle();

        // Saturation with a request held through RISE
        trig_valid = 1'b1; trig_amp = 16'd60000;
        tick();
        trig_valid = 1'b0;
        step_out("sat_r1", 15000);
        trig_valid = 1'b1;
        step_out("sat_r2", 30000);
        check("sat_hold_ready", trig_ready, 0);
        step_out("sat_r3", 45000);
        step_out("sat_peak", 60000);
        check("sat_ready", trig_ready, 1);
        step_out("sat_accept", 58125);
        trig_valid = 1'b0;
        check("sat_cnt", pulse_cnt, 6);
        step_out("sat_c1", 65535);
        step_out("sat_c2", 65535);
        step_out("sat_c3", 65535);
        step_out("sat_c4", 65535);
        step_out("sat_d1", 63488);
        wait_idle();

        // Zero amplitude
        trig_valid = 1'b1; trig_amp = '0;
        tick();
        trig_valid = 1'b0;
        check("z_busy", busy, 1);
        check("z_cnt", pulse_cnt, 7);
        repeat (4) step_out("z_out", 0);
        check("z_busy_decay", busy, 1);
        check("z_ready_decay", trig_ready, 1);
        tick();
        check("z_idle", busy, 0);

        // Reset mid-RISE with a held request
        trig_valid = 1'b1; trig_amp = 16'd1024;
        tick();
        step_out("rr_r1", 256);
        reset = 1'b1;
        tick();
        check("rr_out", out, 0);
        check("rr_busy", busy, 0);
        check("rr_cnt", pulse_cnt, 0);
        check("rr_ready", trig_ready, 1);
        reset = 1'b0;
        tick();
        trig_valid = 1'b0;
        check("rr_accept_cnt", pulse_cnt, 1);
        check("rr_accept_busy", busy, 1);
        step_out("rr_r1b", 256);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
